// File: rtl/fir_tx_pkg.sv
// Shared constants and types for the transmit-side FIR sample source.
package fir_tx_pkg;

    localparam logic [2:0] SYM_M3 = 3'b101;
    localparam logic [2:0] SYM_M1 = 3'b111;
    localparam logic [2:0] SYM_P1 = 3'b001;
    localparam logic [2:0] SYM_P3 = 3'b011;

    localparam int unsigned CLK_DIV_DEFAULT = 20;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    // Gray-coded dibit to 4-level signed sample.
    function automatic logic [2:0] gray_map(input logic [1:0] pair);
        logic [2:0] sym;
        case (pair)
            2'b00:   sym = SYM_M3;
            2'b01:   sym = SYM_M1;
            2'b11:   sym = SYM_P1;
            default: sym = SYM_P3;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Free-running clock divider producing a one-cycle tick every CLK_DIV cycles.
module sample_strobe_gen
    import fir_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic iClk,
    input  logic iRst,
    output logic oTick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign oTick = (r_cnt == LAST);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_cnt <= '0;
        end else if (oTick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_symbol_source.sv
// Byte-to-symbol serializer with zero-stuffing; producer of the FIR input strobe and sample.
module fir_symbol_source
    import fir_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEFAULT,
    parameter int unsigned UPSAMPLE = 4
) (
    input  logic       iClk_12MHz,
    input  logic       iRst,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       oEnSample_600kHz,
    output logic [2:0] oFirIn,
    output logic       oBusy
);

    localparam logic [2:0] LAST_PH = 3'(UPSAMPLE - 1);

    logic       w_tick;
    state_e     r_state, w_state_next;
    logic [7:0] r_hold;
    logic       r_hold_valid;
    logic [7:0] r_shift, w_shift_next;
    logic [2:0] r_phase, w_phase_next;
    logic [1:0] r_sym, w_sym_next;
    logic       r_en;
    logic [2:0] r_fir, w_fir_next;
    logic       w_load;
    logic [1:0] w_pair;

    sample_strobe_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_strobe (
        .iClk (iClk_12MHz),
        .iRst (iRst),
        .oTick(w_tick)
    );

    always_comb begin
        case (r_sym)
            2'd0:    w_pair = r_shift[7:6];
            2'd1:    w_pair = r_shift[5:4];
            2'd2:    w_pair = r_shift[3:2];
            default: w_pair = r_shift[1:0];
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_phase_next = r_phase;
        w_sym_next   = r_sym;
        w_fir_next   = r_fir;
        w_load       = 1'b0;
        if (w_tick) begin
            w_fir_next = 3'b000;
            // phase==0 with sym==0 in SEND is the byte boundary: symbol 0 is emitted on load.
            if ((r_state == IDLE) || (r_phase == 3'd0 && r_sym == 2'd0)) begin
                if (r_hold_valid) begin
                    w_load       = 1'b1;
                    w_shift_next = r_hold;
                    w_fir_next   = gray_map(r_hold[7:6]);
                    w_phase_next = 3'd1;
                    w_sym_next   = 2'd0;
                    w_state_next = SEND;
                end else begin
                    w_state_next = IDLE;
                end
            end else begin
                if (r_phase == 3'd0) begin
                    w_fir_next = gray_map(w_pair);
                end
                if (r_phase == LAST_PH) begin
                    w_phase_next = 3'd0;
                    w_sym_next   = r_sym + 2'd1;
                end else begin
                    w_phase_next = r_phase + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge iClk_12MHz or posedge iRst) begin
        if (iRst) begin
            r_state      <= IDLE;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
            r_shift      <= 8'h00;
            r_phase      <= 3'd0;
            r_sym        <= 2'd0;
            r_en         <= 1'b0;
            r_fir        <= 3'b000;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_phase <= w_phase_next;
            r_sym   <= w_sym_next;
            r_en    <= w_tick;
            r_fir   <= w_fir_next;
            if (iValid && !r_hold_valid) begin
                r_hold       <= iData;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign oReady           = ~r_hold_valid;
    assign oBusy            = (r_state == SEND);
    assign oEnSample_600kHz = r_en;
    assign oFirIn           = r_fir;

endmodule

// File: tb/tb_fir_symbol_source.sv
// Directed, table-driven bench for fir_symbol_source (default and fast-rate instances).
module tb_fir_symbol_source;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data, data2;
    logic       valid, valid2;
    logic       ready, en, busy;
    logic       ready2, en2, busy2;
    logic [2:0] fir, fir2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_symbol_source #(
        .CLK_DIV (20),
        .UPSAMPLE(4)
    ) dut (
        .iClk_12MHz      (clk),
        .iRst            (rst),
        .iData           (data),
        .iValid          (valid),
        .oReady          (ready),
        .oEnSample_600kHz(en),
        .oFirIn          (fir),
        .oBusy           (busy)
    );

    fir_symbol_source #(
        .CLK_DIV (2),
        .UPSAMPLE(2)
    ) dut2 (
        .iClk_12MHz      (clk),
        .iRst            (rst),
        .iData           (data2),
        .iValid          (valid2),
        .oReady          (ready2),
        .oEnSample_600kHz(en2),
        .oFirIn          (fir2),
        .oBusy           (busy2)
    );

    typedef struct {
        logic [7:0]  data;
        logic [11:0] syms;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [2:0] exp_sample(input logic [11:0] syms, input int s);
        if (s % 4 != 0) return 3'b000;
        return 3'(syms >> (9 - 3 * (s / 4)));
    endfunction

    // Called at a negedge; returns at the negedge following the next strobe edge.
    task automatic wait_strobe(output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 64) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (en) seen = 1'b1;
        end
        if (!seen) timeout_fail("strobe_wait");
    endtask

    task automatic wait_strobe2(output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 16) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (en2) seen = 1'b1;
        end
        if (!seen) timeout_fail("strobe2_wait");
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        int n = 0;
        data  = b;
        valid = 1'b1;
        while (!done && n < 200) begin
            if (ready) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        valid = 1'b0;
        if (!done) timeout_fail("send_accept");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{data: 8'h1E, syms: 12'b101_111_001_011};
        vecs[1] = '{data: 8'hFF, syms: 12'b001_001_001_001};
        vecs[2] = '{data: 8'h00, syms: 12'b101_101_101_101};
        vecs[3] = '{data: 8'hB4, syms: 12'b011_001_111_101};
        vecs[4] = '{data: 8'h9C, syms: 12'b011_111_001_101};

        rst    = 1'b1;
        data   = 8'h00;
        valid  = 1'b0;
        data2  = 8'h00;
        valid2 = 1'b0;
        #1;
        check("rst_en", 32'(en), 32'd0);
        check("rst_fir", 32'(fir), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle: strobes on edges 20,40,...,100 after release, samples all zero.
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_en", 32'(en), 32'((n % 20) == 0));
            if (en) check("idle_fir", 32'(fir), 32'd0);
        end
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Single bytes followed by underrun.
        for (int v = 0; v < 5; v++) begin
            send_byte(vecs[v].data);
            for (int s = 0; s < 16; s++) begin
                wait_strobe(cyc);
                check("byte_sample", 32'(fir), 32'(exp_sample(vecs[v].syms, s)));
                check("byte_busy", 32'(busy), 32'd1);
                if (s > 0) check("byte_period", 32'(cyc), 32'd20);
            end
            for (int u = 0; u < 2; u++) begin
                wait_strobe(cyc);
                check("underrun_fir", 32'(fir), 32'd0);
                check("underrun_busy", 32'(busy), 32'd0);
                check("underrun_ready", 32'(ready), 32'd1);
                check("underrun_period", 32'(cyc), 32'd20);
            end
        end

        // Back-to-back 0x1E then 0xB4 with iValid held high.
        send_byte(8'h1E);
        check("b2b_held_off", 32'(ready), 32'd0);
        fork
            send_byte(8'hB4);
            begin
                for (int s = 0; s < 32; s++) begin
                    wait_strobe(cyc);
                    if (s == 0) check("b2b_ready_after_load", 32'(ready), 32'd1);
                    check("b2b_sample", 32'(fir),
                          32'(exp_sample((s < 16) ? vecs[0].syms : vecs[3].syms, s % 16)));
                    check("b2b_busy", 32'(busy), 32'd1);
                end
                wait_strobe(cyc);
                check("b2b_end_fir", 32'(fir), 32'd0);
                check("b2b_end_busy", 32'(busy), 32'd0);
            end
        join

        // Asynchronous reset mid-byte at symbol 2 with a second byte held.
        send_byte(8'h1E);
        wait_strobe(cyc);
        send_byte(8'hB4);
        for (int s = 1; s < 9; s++) wait_strobe(cyc);
        check("pre_rst_fir", 32'(fir), 32'b001);
        check("pre_rst_ready", 32'(ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_en", 32'(en), 32'd0);
        check("async_fir", 32'(fir), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wait_strobe(cyc);
        check("post_rst_first", 32'(cyc), 32'd20);
        check("post_rst_fir", 32'(fir), 32'd0);
        wait_strobe(cyc);
        check("post_rst_discard_fir", 32'(fir), 32'd0);
        check("post_rst_discard_busy", 32'(busy), 32'd0);

        // Fast instance: UPSAMPLE=2, CLK_DIV=2, byte 0x00.
        data2  = 8'h00;
        valid2 = 1'b1;
        check("fast_ready", 32'(ready2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        for (int s = 0; s < 10; s++) begin
            wait_strobe2(cyc);
            check("fast_sample", 32'(fir2), (s < 8 && (s % 2) == 0) ? 32'b101 : 32'd0);
            if (s > 0) check("fast_period", 32'(cyc), 32'd2);
        end
        check("fast_busy_end", 32'(busy2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
